// File: rtl/board_compactor.sv
`default_nettype none
// ============================================================================
// Module   : board_compactor
// Brief    : Line-clear sequencer for the board RAM. Drops full rows, shifts
//            the remaining rows down and zero-fills the vacated top rows.
// Revision : 1.0
// ============================================================================
module board_compactor #(
    parameter int COLS = 10,
    parameter int ROWS = 12,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [3:0]    lines_cleared,
    output logic [15:0]   total_lines,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wdata,
    input  logic [3:0]    mem_rdata
);

    localparam int PW = $clog2(ROWS) + 1;
    localparam int CW = $clog2(COLS);
    localparam logic [PW-1:0] c_TOP      = PW'(ROWS - 1);
    localparam logic [CW-1:0] c_LAST_COL = CW'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_FILL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_src;
    logic signed [PW-1:0]  r_dst;
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_cap_col;
    logic                  r_rd_pend;
    logic                  r_full;
    logic [3:0]            r_cnt;
    logic                  r_done;
    logic [3:0]            r_lines;
    logic [15:0]           r_total;
    logic                  r_req;
    logic                  r_we;
    logic [AW-1:0]         r_addr;
    logic [3:0]            r_wdata;
    logic [3:0]            r_line [COLS];

    logic                  w_granted;
    logic                  w_go_next;
    logic [3:0]            w_cnt_nx;
    logic signed [PW-1:0]  w_dst_nx;
    logic [16:0]           w_total_sum;

    function automatic logic [AW-1:0] f_base(input logic [PW-1:0] row);
        f_base = AW'(int'(row) * COLS);
    endfunction

    assign w_granted   = r_req & mem_gnt;
    assign w_total_sum = {1'b0, r_total} + 17'(w_cnt_nx);

    // Row-exit decision shared by CHECK and the final granted WRITE cycle.
    always_comb begin
        w_cnt_nx  = r_cnt;
        w_dst_nx  = r_dst;
        w_go_next = 1'b0;
        case (r_state)
            S_CHECK: begin
                if (r_full) begin
                    w_cnt_nx  = r_cnt + 4'd1;
                    w_go_next = 1'b1;
                end else if ($unsigned(r_dst) == r_src) begin
                    w_dst_nx  = r_dst - PW'(1);
                    w_go_next = 1'b1;
                end
            end
            S_WRITE: begin
                if (w_granted && (r_col == c_LAST_COL)) begin
                    w_dst_nx  = r_dst - PW'(1);
                    w_go_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_src     <= c_TOP;
            r_dst     <= c_TOP;
            r_col     <= '0;
            r_cap_col <= '0;
            r_rd_pend <= 1'b0;
            r_full    <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_lines   <= '0;
            r_total   <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_rd_pend <= (r_state == S_READ) && w_granted;
            r_cap_col <= r_col;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= c_TOP;
                        r_dst   <= c_TOP;
                        r_cnt   <= '0;
                        r_col   <= '0;
                        r_full  <= 1'b1;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= f_base(c_TOP);
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_granted) begin
                        if (r_col == c_LAST_COL) begin
                            r_req <= 1'b0;
                        end else begin
                            r_col  <= r_col + CW'(1);
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                    if (r_rd_pend) begin
                        r_full <= r_full & (mem_rdata != 4'd0);
                        if (r_cap_col == c_LAST_COL) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK, S_WRITE: begin
                    r_cnt <= w_cnt_nx;
                    r_dst <= w_dst_nx;
                    if (w_go_next) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_col   <= '0;
                        r_wdata <= '0;
                        if (r_src != '0) begin
                            r_src   <= r_src - PW'(1);
                            r_full  <= 1'b1;
                            r_req   <= 1'b1;
                            r_addr  <= f_base(r_src - PW'(1));
                            r_state <= S_READ;
                        end else if (w_cnt_nx != 4'd0) begin
                            r_req   <= 1'b1;
                            r_we    <= 1'b1;
                            r_addr  <= f_base($unsigned(w_dst_nx));
                            r_state <= S_FILL;
                        end else begin
                            r_done  <= 1'b1;
                            r_lines <= w_cnt_nx;
                            r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
                            r_state <= S_DONE;
                        end
                    end else if (r_state == S_CHECK) begin
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_col   <= '0;
                        r_addr  <= f_base($unsigned(r_dst));
                        r_wdata <= r_line[0];
                        r_state <= S_WRITE;
                    end else if (w_granted) begin
                        r_col   <= r_col + CW'(1);
                        r_addr  <= r_addr + AW'(1);
                        r_wdata <= r_line[r_col + CW'(1)];
                    end
                end
                S_FILL: begin
                    if (w_granted) begin
                        if (r_col == c_LAST_COL) begin
                            if (r_dst == '0) begin
                                r_req   <= 1'b0;
                                r_we    <= 1'b0;
                                r_done  <= 1'b1;
                                r_lines <= w_cnt_nx;
                                r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
                                r_state <= S_DONE;
                            end else begin
                                r_dst  <= r_dst - PW'(1);
                                r_col  <= '0;
                                r_addr <= f_base($unsigned(r_dst - PW'(1)));
                            end
                        end else begin
                            r_col  <= r_col + CW'(1);
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line buffer is pure datapath; its contents only matter after a full READ.
    always_ff @(posedge clk) begin
        if ((r_state == S_READ) && r_rd_pend) begin
            r_line[r_cap_col] <= mem_rdata;
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign lines_cleared = r_lines;
    assign total_lines   = r_total;
    assign mem_req       = r_req;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_board_compactor.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_compactor
// Brief    : Directed self-checking bench for board_compactor with a RAM model.
// Revision : 1.0
// ============================================================================
module tb_board_compactor;

    localparam int COLS = 10;
    localparam int ROWS = 12;
    localparam int AW   = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          gnt;
    logic          busy;
    logic          done;
    logic [3:0]    lines;
    logic [15:0]   total;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wdata;
    logic [3:0]    rdata;

    logic [3:0]    mem     [0:127];
    logic [3:0]    img     [0:127];
    logic [3:0]    exp_img [0:127];
    logic          load_req = 1'b0;
    int            wr_cnt = 0;
    logic          stall_mode = 1'b0;
    int            stall_cycles;
    int            stall_viol;

    int            total_chk = 0;
    int            bad = 0;

    board_compactor #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines),
        .total_lines   (total),
        .mem_req       (mem_req),
        .mem_gnt       (gnt),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (rdata)
    );

    always #5 clk = ~clk;

    // Board RAM model: one-cycle read latency, writes on granted cycles.
    always @(posedge clk) begin
        if (load_req) begin
            mem = img;
        end else if (mem_req && gnt) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rdata <= mem[mem_addr];
            end
        end
    end

    // Grant driver and stall-stability monitor.
    initial begin : gnt_mon
        logic          prev_req, prev_gnt, prev_we;
        logic [AW-1:0] prev_addr;
        logic [3:0]    prev_wdata;
        int            k;
        prev_req = 1'b0; prev_gnt = 1'b1; prev_we = 1'b0;
        prev_addr = '0; prev_wdata = '0; k = 0;
        stall_cycles = 0; stall_viol = 0;
        gnt = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_req && !prev_gnt) begin
                if (mem_req !== prev_req || mem_we !== prev_we ||
                    mem_addr !== prev_addr || mem_wdata !== prev_wdata)
                    stall_viol = stall_viol + 1;
            end
            prev_req = mem_req; prev_we = mem_we;
            prev_addr = mem_addr; prev_wdata = mem_wdata;
            if (stall_mode) begin
                gnt = ((k % 3) == 0);
                k = k + 1;
            end else begin
                gnt = 1'b1;
            end
            prev_gnt = gnt;
            if (mem_req && !gnt) stall_cycles = stall_cycles + 1;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_board();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_imgs();
        for (int i = 0; i < 128; i++) begin
            img[i]     = 4'd0;
            exp_img[i] = 4'd0;
        end
    endtask

    task automatic setup_one_full();
        clear_imgs();
        for (int c = 0; c < COLS; c++) img[110 + c] = 4'd3;
        img[100] = 4'd5;
        exp_img[110] = 4'd5;
    endtask

    // Pulses start at a negedge; counts cycles until done is seen (cycle 1 = first after the sampling edge).
    task automatic run_pass(output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_chk++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        total_chk++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", done); end
        total_chk++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0d exp=0", mem_req); end
        total_chk++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0d exp=0", mem_we); end
        total_chk++; if (mem_addr !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
        total_chk++; if (mem_wdata !== 4'd0) begin bad++; $display("FAIL reset_wdata got=%0d exp=0", mem_wdata); end
        total_chk++; if (lines !== 4'd0) begin bad++; $display("FAIL reset_lines got=%0d exp=0", lines); end
        total_chk++; if (total !== 16'd0) begin bad++; $display("FAIL reset_total got=%0d exp=0", total); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int cyc, wr0;
        do_reset();
        clear_imgs();
        load_board();
        wr0 = wr_cnt;
        run_pass(cyc);
        total_chk++; if (cyc !== 145) begin bad++; $display("FAIL empty_cycle got=%0d exp=145", cyc); end
        total_chk++; if (lines !== 4'd0) begin bad++; $display("FAIL empty_lines got=%0d exp=0", lines); end
        total_chk++; if (total !== 16'd0) begin bad++; $display("FAIL empty_total got=%0d exp=0", total); end
        total_chk++; if (wr_cnt - wr0 !== 0) begin bad++; $display("FAIL empty_writes got=%0d exp=0", wr_cnt - wr0); end
        for (int i = 0; i < ROWS * COLS; i++) begin
            total_chk++;
            if (mem[i] !== exp_img[i]) begin bad++; $display("FAIL empty_cell[%0d] got=%0d exp=%0d", i, mem[i], exp_img[i]); end
        end
        @(negedge clk);
        total_chk++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_idle got=%0d exp=0", busy); end
    endtask

    task automatic test_one_full();
        int cyc, wr0;
        do_reset();
        setup_one_full();
        load_board();
        wr0 = wr_cnt;
        run_pass(cyc);
        total_chk++; if (cyc !== 265) begin bad++; $display("FAIL one_cycle got=%0d exp=265", cyc); end
        total_chk++; if (lines !== 4'd1) begin bad++; $display("FAIL one_lines got=%0d exp=1", lines); end
        total_chk++; if (total !== 16'd1) begin bad++; $display("FAIL one_total got=%0d exp=1", total); end
        total_chk++; if (wr_cnt - wr0 !== 120) begin bad++; $display("FAIL one_writes got=%0d exp=120", wr_cnt - wr0); end
        for (int i = 0; i < ROWS * COLS; i++) begin
            total_chk++;
            if (mem[i] !== exp_img[i]) begin bad++; $display("FAIL one_cell[%0d] got=%0d exp=%0d", i, mem[i], exp_img[i]); end
        end
        @(negedge clk);
        total_chk++; if (done !== 1'b0) begin bad++; $display("FAIL one_done_pulse got=%0d exp=0", done); end
        total_chk++; if (lines !== 4'd1) begin bad++; $display("FAIL one_lines_hold got=%0d exp=1", lines); end
    endtask

    task automatic test_two_full();
        int cyc, wr0;
        do_reset();
        clear_imgs();
        for (int c = 0; c < COLS; c++) begin
            img[110 + c] = 4'd7;
            img[90 + c]  = 4'd4;
        end
        img[100] = 4'd1; img[101] = 4'd2;
        img[80]  = 4'd2; img[89]  = 4'd6;
        exp_img[110] = 4'd1; exp_img[111] = 4'd2;
        exp_img[100] = 4'd2; exp_img[109] = 4'd6;
        load_board();
        wr0 = wr_cnt;
        run_pass(cyc);
        total_chk++; if (cyc !== 265) begin bad++; $display("FAIL two_cycle got=%0d exp=265", cyc); end
        total_chk++; if (lines !== 4'd2) begin bad++; $display("FAIL two_lines got=%0d exp=2", lines); end
        total_chk++; if (total !== 16'd2) begin bad++; $display("FAIL two_total got=%0d exp=2", total); end
        total_chk++; if (wr_cnt - wr0 !== 120) begin bad++; $display("FAIL two_writes got=%0d exp=120", wr_cnt - wr0); end
        for (int i = 0; i < ROWS * COLS; i++) begin
            total_chk++;
            if (mem[i] !== exp_img[i]) begin bad++; $display("FAIL two_cell[%0d] got=%0d exp=%0d", i, mem[i], exp_img[i]); end
        end
    endtask

    task automatic test_stall();
        int cyc, wr0, s0, v0, stalls;
        do_reset();
        setup_one_full();
        load_board();
        wr0 = wr_cnt;
        s0  = stall_cycles;
        v0  = stall_viol;
        stall_mode = 1'b1;
        run_pass(cyc);
        stall_mode = 1'b0;
        stalls = stall_cycles - s0;
        total_chk++; if (stalls < 100) begin bad++; $display("FAIL stall_count got=%0d exp>=100", stalls); end
        total_chk++; if (cyc !== 265 + stalls) begin bad++; $display("FAIL stall_cycle got=%0d exp=%0d", cyc, 265 + stalls); end
        total_chk++; if (stall_viol - v0 !== 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", stall_viol - v0); end
        total_chk++; if (lines !== 4'd1) begin bad++; $display("FAIL stall_lines got=%0d exp=1", lines); end
        total_chk++; if (wr_cnt - wr0 !== 120) begin bad++; $display("FAIL stall_writes got=%0d exp=120", wr_cnt - wr0); end
        for (int i = 0; i < ROWS * COLS; i++) begin
            total_chk++;
            if (mem[i] !== exp_img[i]) begin bad++; $display("FAIL stall_cell[%0d] got=%0d exp=%0d", i, mem[i], exp_img[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        do_reset();
        setup_one_full();
        load_board();
        n_done = 0;
        for (int i = 0; i < 600; i++) begin
            start = (i == 0 || i == 40 || i == 200);
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        start = 1'b0;
        total_chk++; if (n_done !== 1) begin bad++; $display("FAIL restart_dones got=%0d exp=1", n_done); end
        total_chk++; if (total !== 16'd1) begin bad++; $display("FAIL restart_total got=%0d exp=1", total); end
        total_chk++; if (lines !== 4'd1) begin bad++; $display("FAIL restart_lines got=%0d exp=1", lines); end
        total_chk++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_idle got=%0d exp=0", busy); end
    endtask

    // Runs on from test_back_to_back so lines/total are nonzero when reset hits.
    task automatic test_reset_mid_write();
        int cyc, n;
        setup_one_full();
        load_board();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (mem_we !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total_chk++; if (mem_we !== 1'b1) begin bad++; $display("FAIL midwr_reach got=%0d exp=1", mem_we); end
        #2 reset = 1'b1;
        #1;
        total_chk++; if (busy !== 1'b0) begin bad++; $display("FAIL midwr_busy got=%0d exp=0", busy); end
        total_chk++; if (done !== 1'b0) begin bad++; $display("FAIL midwr_done got=%0d exp=0", done); end
        total_chk++; if (mem_req !== 1'b0) begin bad++; $display("FAIL midwr_req got=%0d exp=0", mem_req); end
        total_chk++; if (lines !== 4'd0) begin bad++; $display("FAIL midwr_lines got=%0d exp=0", lines); end
        total_chk++; if (total !== 16'd0) begin bad++; $display("FAIL midwr_total got=%0d exp=0", total); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_chk++; if (busy !== 1'b0) begin bad++; $display("FAIL midwr_idle got=%0d exp=0", busy); end
        setup_one_full();
        load_board();
        run_pass(cyc);
        total_chk++; if (cyc !== 265) begin bad++; $display("FAIL rerun_cycle got=%0d exp=265", cyc); end
        total_chk++; if (lines !== 4'd1) begin bad++; $display("FAIL rerun_lines got=%0d exp=1", lines); end
        total_chk++; if (total !== 16'd1) begin bad++; $display("FAIL rerun_total got=%0d exp=1", total); end
        for (int i = 0; i < ROWS * COLS; i++) begin
            total_chk++;
            if (mem[i] !== exp_img[i]) begin bad++; $display("FAIL rerun_cell[%0d] got=%0d exp=%0d", i, mem[i], exp_img[i]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_empty();
        test_one_full();
        test_two_full();
        test_stall();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total_chk, bad);
        $finish;
    end

endmodule
`default_nettype wire
